// File: rtl/joy_pkg.sv
// Shared types and helpers for the serial joystick reader.
package joy_pkg;

    localparam int JOY_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } joy_state_e;

    // Load + (low,high) per bit + done, followed by the idle gap.
    function automatic int joy_frame_ticks(input int players, input int bits, input int gap_ticks);
        return 2 + 2 * players * bits + gap_ticks;
    endfunction

endpackage

// File: rtl/joy_debounce.sv
// Per-bit frame debouncer: a bit changes only after DEBOUNCE consecutive differing frames.
module joy_debounce #(
    parameter int N        = 32,
    parameter int DEBOUNCE = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         strobe,
    input  logic [N-1:0] raw,
    output logic [N-1:0] stable
);

    localparam int            CW      = $clog2(DEBOUNCE) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

    for (genvar i = 0; i < N; i++) begin : g_bit
        logic [CW-1:0] cnt;
        logic          stable_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt      <= '0;
                stable_q <= 1'b0;
            end else if (strobe) begin
                if (raw[i] == stable_q) begin
                    cnt <= '0;
                end else if (cnt + 1'b1 >= CNT_MAX) begin
                    stable_q <= raw[i];
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign stable[i] = stable_q;
    end

endmodule

// File: rtl/joy_shift_reader.sv
// Serial reader for cascaded parallel-in shift-register joystick adapters on UserIO.
module joy_shift_reader
    import joy_pkg::*;
#(
    parameter int PLAYERS   = 2,
    parameter int BITS      = 16,
    parameter int CLK_DIV   = 24,
    parameter int GAP_TICKS = 64,
    parameter int DEBOUNCE  = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     JOY_DATA,
    output logic                     JOY_CLK,
    output logic                     JOY_LOAD,
    output logic [PLAYERS*JOY_W-1:0] joystick,
    output logic                     frame_done
);

    localparam int N     = PLAYERS * BITS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int TW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW    = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    localparam logic [TW-1:0]    TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [GW-1:0]    GAP_LAST  = GW'(GAP_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);

    logic [TW-1:0]    div_cnt;
    logic             tick;
    logic [1:0]       data_sync;
    joy_state_e       state, state_d;
    logic [GW-1:0]    gap_cnt, gap_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic             frame_end;
    logic             sample;
    logic [N-1:0]     shift_raw;
    logic [N-1:0]     stable;
    logic             joy_clk_q, joy_load_q;

    assign tick = (div_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) div_cnt <= '0;
        else          div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    // Idle level of the adapter line is high (nothing pressed).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) data_sync <= 2'b11;
        else          data_sync <= {data_sync[0], JOY_DATA};
    end

    always_comb begin
        state_d   = state;
        gap_d     = gap_cnt;
        idx_d     = idx;
        frame_end = 1'b0;
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_d = '0;
                        if (enable) state_d = ST_LOAD;
                    end else begin
                        gap_d = gap_cnt + 1'b1;
                    end
                end
                ST_LOAD: begin
                    idx_d   = '0;
                    state_d = ST_LOW;
                end
                ST_LOW:  state_d = ST_HIGH;
                ST_HIGH: begin
                    if (idx == IDX_LAST) begin
                        frame_end = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        idx_d   = idx + 1'b1;
                        state_d = ST_LOW;
                    end
                end
                ST_DONE: begin
                    gap_d   = '0;
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sampling on the LOW->HIGH transition is the edge where JOY_CLK rises.
    assign sample = tick && (state == ST_LOW);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            gap_cnt    <= '0;
            idx        <= '0;
            joy_clk_q  <= 1'b1;
            joy_load_q <= 1'b1;
            frame_done <= 1'b0;
            shift_raw  <= '0;
        end else begin
            state      <= state_d;
            gap_cnt    <= gap_d;
            idx        <= idx_d;
            joy_clk_q  <= (state_d != ST_LOW);
            joy_load_q <= (state_d != ST_LOAD);
            frame_done <= frame_end;
            if (sample) shift_raw[idx] <= ~data_sync[1];
        end
    end

    assign JOY_CLK  = joy_clk_q;
    assign JOY_LOAD = joy_load_q;

    joy_debounce #(
        .N        (N),
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (frame_end),
        .raw     (shift_raw),
        .stable  (stable)
    );

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        for (genvar b = 0; b < JOY_W; b++) begin : g_btn
            if (b < BITS) begin : g_used
                assign joystick[JOY_W*p+b] = stable[p*BITS+b];
            end else begin : g_tied
                assign joystick[JOY_W*p+b] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_joy_shift_reader.sv
// Bench for joy_shift_reader: default 2x16 instance plus a 3x12 debounced instance.
module tb_joy_shift_reader;
    import joy_pkg::*;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        rst0 = 1'b0, rst1 = 1'b0, en0 = 1'b1, en1 = 1'b1;
    logic        d0, d1, jclk0, jload0, fd0, jclk1, jload1, fd1;
    logic [31:0] js0;
    logic [47:0] js1;
    logic [63:0] pat0 = '0, pat1 = '0;

    int k0 = 99, k1 = 99;
    int rises0 = 0, rises1 = 0, nload0 = 0;
    int cyc = 0, load_cyc0 = 0, load_prev0 = 0, fd_cyc = 0;
    int n_cmp = 0, n_err = 0;
    logic [63:0] exp_q[$];

    joy_shift_reader #(.PLAYERS(2), .BITS(16), .CLK_DIV(24), .GAP_TICKS(64), .DEBOUNCE(1)) u0 (
        .clk(clk), .reset_n(rst0), .enable(en0), .JOY_DATA(d0),
        .JOY_CLK(jclk0), .JOY_LOAD(jload0), .joystick(js0), .frame_done(fd0));

    joy_shift_reader #(.PLAYERS(3), .BITS(12), .CLK_DIV(4), .GAP_TICKS(4), .DEBOUNCE(3)) u1 (
        .clk(clk), .reset_n(rst1), .enable(en1), .JOY_DATA(d1),
        .JOY_CLK(jclk1), .JOY_LOAD(jload1), .joystick(js1), .frame_done(fd1));

    always @(posedge clk) cyc++;

    // Adapter models: load on LOAD low, shift one position per JOY_CLK rise, serial-in idles high.
    always @(negedge jload0) begin
        k0 = 0; rises0 = 0; nload0++; load_prev0 = load_cyc0; load_cyc0 = cyc;
    end
    always @(posedge jclk0) if (jload0 === 1'b1) begin k0++; rises0++; end
    assign d0 = (k0 < 32) ? ~pat0[k0] : 1'b1;

    always @(negedge jload1) begin k1 = 0; rises1 = 0; end
    always @(posedge jclk1) if (jload1 === 1'b1) begin k1++; rises1++; end
    assign d1 = (k1 < 36) ? ~pat1[k1] : 1'b1;

    function automatic logic [63:0] pk12(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
        return {28'h0, c, b, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_fd(input int inst, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(posedge clk); #1;
            if (((inst == 0) ? fd0 : fd1) === 1'b1) begin
                ok = 1'b1; fd_cyc = cyc; break;
            end
        end
    endtask

    task automatic frame(input int inst, input string tag);
        bit ok;
        logic [63:0] e;
        wait_fd(inst, ok);
        chk({tag, "_seen"}, 64'(ok), 64'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        chk(tag, (inst == 0) ? 64'(js0) : 64'(js1), e);
        chk({tag, "_clks"}, 64'((inst == 0) ? rises0 : rises1), 64'((inst == 0) ? 32 : 36));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 64'((inst == 0) ? fd0 : fd1), 64'd0);
    endtask

    task automatic wait_load0(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(posedge clk); #1;
            if (jload0 === 1'b0) begin ok = 1'b1; break; end
        end
        chk({tag, "_load"}, 64'(ok), 64'd1);
    endtask

    task automatic wait_rises0(input int n, input string tag);
        bit ok = 1'b0;
        wait_load0(tag);
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if (rises0 >= n) begin ok = 1'b1; break; end
        end
        chk({tag, "_rises"}, 64'(ok), 64'd1);
    endtask

    initial begin
        int c0, nb;
        bit ok;
        logic [31:0] r;

        pat0 = {32'h0, 32'h8002_0011};
        pat1 = pk12(12'h010, 12'h000, 12'h000);
        repeat (20) @(posedge clk); #1;
        chk("rst_clk0",  64'(jclk0),  64'd1);
        chk("rst_load0", 64'(jload0), 64'd1);
        chk("rst_js0",   64'(js0),    64'd0);
        chk("rst_fd0",   64'(fd0),    64'd0);
        chk("rst_clk1",  64'(jclk1),  64'd1);
        chk("rst_load1", 64'(jload1), 64'd1);
        chk("rst_js1",   64'(js1),    64'd0);

        @(negedge clk); rst0 = 1'b1; c0 = cyc;
        wait_load0("first");
        chk("first_load_cyc", 64'(load_cyc0 - c0), 64'(64 * 24));
        exp_q.push_back(64'h8002_0011);
        frame(0, "f1");

        r = $urandom;
        pat0 = {32'h0, r};
        exp_q.push_back({32'h0, r});
        frame(0, "f2_rand");
        chk("period", 64'(load_cyc0 - load_prev0), 64'(joy_frame_ticks(2, 16, 64) * 24));

        pat0 = '0;
        exp_q.push_back(64'h0);
        frame(0, "f3_idle_high");

        // Disable mid-frame: this frame still completes, then the FSM idles.
        pat0 = {32'h0, 32'hFFFF_0001};
        exp_q.push_back(64'hFFFF_0001);
        wait_rises0(10, "en_drop");
        en0 = 1'b0;
        frame(0, "f4_en_drop");
        nb = nload0;
        c0 = fd_cyc;
        while (cyc < c0 + 3800) @(posedge clk);
        #1;
        pat0 = {32'h0, 32'h5A5A_C3C3};
        en0 = 1'b1;
        wait_load0("resume");
        chk("dis_loads", 64'(nload0 - nb), 64'd1);
        chk("resume_cyc", 64'(load_cyc0 - c0), 64'(24 + 3 * 64 * 24));
        exp_q.push_back(64'h5A5A_C3C3);
        frame(0, "f5_resume");

        // Reset during a frame; the partial frame must never be published.
        pat0 = {32'h0, 32'h0F0F_F0F0};
        wait_rises0(20, "mid_rst");
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (jclk0 === 1'b0) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("mid_rst_low", 64'(ok), 64'd1);
        rst0 = 1'b0; #1;
        chk("mid_rst_clk",  64'(jclk0),  64'd1);
        chk("mid_rst_load", 64'(jload0), 64'd1);
        chk("mid_rst_js",   64'(js0),    64'd0);
        chk("mid_rst_fd",   64'(fd0),    64'd0);
        repeat (10) @(posedge clk);
        pat0 = {32'h0, 32'h7E81_1818};
        exp_q.push_back(64'h7E81_1818);
        @(negedge clk); rst0 = 1'b1;
        frame(0, "f6_after_rst");

        // 3x12 instance with DEBOUNCE=3: single glitch rejected, held change accepted on 3rd frame.
        @(negedge clk); rst1 = 1'b1;
        exp_q.push_back(64'h0);
        frame(1, "d_glitch");
        pat1 = '0;
        exp_q.push_back(64'h0);
        frame(1, "d_clear");
        pat1 = pk12(12'h010, 12'h000, 12'h000);
        exp_q.push_back(64'h0);
        frame(1, "d_hold1");
        exp_q.push_back(64'h0);
        frame(1, "d_hold2");
        exp_q.push_back(64'h0000_0000_0000_0010);
        frame(1, "d_hold3");
        pat1 = pk12(12'hABC, 12'hABC, 12'hABC);
        exp_q.push_back(64'h0000_0000_0000_0010);
        frame(1, "d_abc1");
        exp_q.push_back(64'h0000_0000_0000_0010);
        frame(1, "d_abc2");
        exp_q.push_back(64'h0000_0ABC_0ABC_0ABC);
        frame(1, "d_abc3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
